// File: rtl/dcnn_pkg.sv
// Shared types for the DCNN accelerator datapath stages.
package dcnn_pkg;

  localparam int DATA_W = 16;

  typedef logic signed [DATA_W-1:0] score_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } fc_argmax_state_t;

endpackage

// File: rtl/fc_argmax.sv
// Streaming argmax over one frame of NUM_CLASSES signed scores; result held
// on a valid/ready output until the consumer takes it.
module fc_argmax
  import dcnn_pkg::*;
#(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = dcnn_pkg::DATA_W,
  localparam int IDX_W      = (NUM_CLASSES > 2) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_class,
  output logic [DATA_W-1:0] out_score,
  output logic              busy,
  output logic              err_len
);

  fc_argmax_state_t r_state, w_state_nxt;

  logic [IDX_W-1:0]         r_count;
  logic [IDX_W-1:0]         r_idx;
  logic signed [DATA_W-1:0] r_max;
  logic                     r_err_len;

  logic w_beat;
  logic w_final_beat;
  logic w_take;

  assign w_beat       = in_valid && (r_state == SCAN);
  assign w_final_beat = (r_count == IDX_W'(NUM_CLASSES - 1));
  // first beat always loads; strict > keeps the lower index on ties
  assign w_take       = (r_count == '0) || ($signed(in_data) > r_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (start) w_state_nxt = SCAN;
      SCAN: if (w_beat && w_final_beat) w_state_nxt = HOLD;
      HOLD: if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_idx     <= '0;
      r_max     <= '0;
      r_err_len <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_count   <= '0;
      r_err_len <= 1'b0;
    end else if (w_beat) begin
      if (w_take) begin
        r_max <= $signed(in_data);
        r_idx <= r_count;
      end
      r_count <= r_count + 1'b1;
      // in_last only flags a mismatch; frame length is fixed by the counter
      if (in_last != w_final_beat) begin
        r_err_len <= 1'b1;
      end
    end
  end

  assign in_ready  = (r_state == SCAN);
  assign out_valid = (r_state == HOLD);
  assign busy      = (r_state != IDLE);
  assign out_class = r_idx;
  assign out_score = r_max;
  assign err_len   = r_err_len;

endmodule

// File: tb/tb_fc_argmax.sv
// Scoreboard bench for fc_argmax: a 4-class and a 10-class instance.
module tb_fc_argmax;
  import dcnn_pkg::*;

  typedef struct {
    int     cls;
    score_t score;
    logic   err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  exp_t q4[$];
  exp_t q10[$];

  // 4-class instance
  logic        a_start = 0, a_in_valid = 0, a_in_last = 0, a_out_ready = 1;
  logic [15:0] a_in_data = '0;
  logic        a_in_ready, a_out_valid, a_busy, a_err_len;
  logic [1:0]  a_out_class;
  logic [15:0] a_out_score;

  fc_argmax #(.NUM_CLASSES(4), .DATA_W(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(a_start), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_class(a_out_class),
    .out_score(a_out_score), .busy(a_busy), .err_len(a_err_len)
  );

  // 10-class instance
  logic        b_start = 0, b_in_valid = 0, b_in_last = 0, b_out_ready = 0;
  logic [15:0] b_in_data = '0;
  logic        b_in_ready, b_out_valid, b_busy, b_err_len;
  logic [3:0]  b_out_class;
  logic [15:0] b_out_score;

  fc_argmax #(.NUM_CLASSES(10), .DATA_W(16)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_class(b_out_class),
    .out_score(b_out_score), .busy(b_busy), .err_len(b_err_len)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop on the rising out_valid, then require stability while held.
  exp_t cur4, cur10;
  logic a_prev_v = 1'b0, b_prev_v = 1'b0;

  always @(negedge clk) begin
    if (a_out_valid) begin
      if (!a_prev_v) begin
        if (q4.size() == 0) begin
          n_checks++; n_errs++;
          $display("FAIL a_unexpected_result: got class %0d expected no result", a_out_class);
        end else begin
          cur4 = q4.pop_front();
          chk("a_class", int'(a_out_class), cur4.cls);
          chk("a_score", int'($signed(a_out_score)), int'(cur4.score));
          chk("a_err_len", int'(a_err_len), int'(cur4.err));
        end
      end else begin
        chk("a_class_stable", int'(a_out_class), cur4.cls);
        chk("a_score_stable", int'($signed(a_out_score)), int'(cur4.score));
      end
    end
    a_prev_v = a_out_valid;
  end

  always @(negedge clk) begin
    if (b_out_valid) begin
      if (!b_prev_v) begin
        if (q10.size() == 0) begin
          n_checks++; n_errs++;
          $display("FAIL b_unexpected_result: got class %0d expected no result", b_out_class);
        end else begin
          cur10 = q10.pop_front();
          chk("b_class", int'(b_out_class), cur10.cls);
          chk("b_score", int'($signed(b_out_score)), int'(cur10.score));
          chk("b_err_len", int'(b_err_len), int'(cur10.err));
        end
      end else begin
        chk("b_class_stable", int'(b_out_class), cur10.cls);
        chk("b_score_stable", int'($signed(b_out_score)), int'(cur10.score));
      end
    end
    b_prev_v = b_out_valid;
  end

  // Full 4-beat frame on the 4-class instance, out_ready held high.
  // Called #1 after a rising edge with the block in IDLE.
  task automatic send4(input score_t s0, input score_t s1, input score_t s2,
                       input score_t s3, input int last_pos,
                       input int exp_cls, input score_t exp_score, input logic exp_err);
    score_t sv [4];
    exp_t   e;
    sv[0] = s0; sv[1] = s1; sv[2] = s2; sv[3] = s3;
    e.cls = exp_cls; e.score = exp_score; e.err = exp_err;
    q4.push_back(e);
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    chk("a_ready_after_start", int'(a_in_ready), 1);
    chk("a_err_cleared_on_start", int'(a_err_len), 0);
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = sv[i];
      a_in_last  = (i == last_pos);
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
    chk("a_latency_out_valid", int'(a_out_valid), 1);
    chk("a_latency_in_ready", int'(a_in_ready), 0);
    @(posedge clk); #1;
    chk("a_idle_after_accept", int'(a_busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    score_t d10 [10];
    exp_t   e;
    d10 = '{16'sd12, -16'sd5, 16'sd40, 16'sd40, 16'sd7, -16'sd300, 16'sd39, 16'sd41, 16'sd0, 16'sd41};

    #12;
    chk("rst_in_ready", int'(a_in_ready), 0);
    chk("rst_out_valid", int'(a_out_valid), 0);
    chk("rst_out_class", int'(a_out_class), 0);
    chk("rst_out_score", int'(a_out_score), 0);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_err_len", int'(a_err_len), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    send4(16'sd3, -16'sd2, 16'sd9, 16'sd1, 3, 2, 16'sd9, 1'b0);
    send4(16'sd5, 16'sd5, -16'sd1, 16'sd5, 3, 0, 16'sd5, 1'b0);
    send4(-16'sd100, -16'sd7, -16'sd32768, -16'sd8, 3, 1, -16'sd7, 1'b0);
    // early in_last: flagged, frame still runs to 4 beats
    send4(16'sd1, 16'sd2, 16'sd3, 16'sd4, 1, 3, 16'sd4, 1'b1);
    chk("a_err_sticky_idle", int'(a_err_len), 1);
    // missing in_last on the final beat
    send4(16'sd8, 16'sd2, 16'sd3, 16'sd1, -1, 0, 16'sd8, 1'b1);
    send4(16'sd2, 16'sd6, 16'sd3, 16'sd1, 3, 1, 16'sd6, 1'b0);

    // 10-class: gaps, start pulses in SCAN and HOLD, out_ready low 5 cycles
    e.cls = 7; e.score = 16'sd41; e.err = 1'b0;
    q10.push_back(e);
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        b_in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      b_start    = (i == 4);
      b_in_valid = 1'b1;
      b_in_data  = d10[i];
      b_in_last  = (i == 9);
      @(posedge clk); #1;
      b_start = 1'b0;
    end
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
    chk("b_latency_out_valid", int'(b_out_valid), 1);
    repeat (2) begin @(posedge clk); #1; end
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("b_hold_out_valid", int'(b_out_valid), 1);
    chk("b_hold_busy", int'(b_busy), 1);
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    chk("b_idle_out_valid", int'(b_out_valid), 0);
    @(posedge clk); #1;
    chk("b_start_not_queued", int'(b_busy), 0);

    // asynchronous reset after two beats of a frame
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    a_in_valid = 1'b1; a_in_data = 16'sd50;
    @(posedge clk); #1;
    a_in_data = 16'sd100; a_in_last = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_in_last = 1'b0;
    chk("a_pre_reset_score", int'($signed(a_out_score)), 100);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", int'(a_in_ready), 0);
    chk("arst_out_valid", int'(a_out_valid), 0);
    chk("arst_out_class", int'(a_out_class), 0);
    chk("arst_out_score", int'(a_out_score), 0);
    chk("arst_busy", int'(a_busy), 0);
    chk("arst_err_len", int'(a_err_len), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send4(16'sd0, 16'sd1, 16'sd2, 16'sd3, 3, 3, 16'sd3, 1'b0);

    repeat (3) begin @(posedge clk); #1; end
    chk("q4_drained", q4.size(), 0);
    chk("q10_drained", q10.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
